// File: rtl/mips32.sv
// rtl/mips32.sv - five-stage pipelined MIPS32-subset core with unified memory; MUL enabled by `MIPS32_MUL_EN
module mips32 #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ = 6'b001110, OP_HLT  = 6'b111111;

  logic [31:0] mem [0:MEM_DEPTH-1];
  logic [31:0] reg_file [0:31];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  // Sticky once an HLT has left ID: keeps PC frozen after the HLT moves on.
  logic        fetch_stop;

  logic [31:0] if_id_ir, if_id_npc;
  logic        if_id_valid;
  logic [31:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
  logic [5:0]  id_ex_op;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_valid;
  logic [31:0] ex_mem_alu, ex_mem_b;
  logic [4:0]  ex_mem_dst;
  logic        ex_mem_valid, ex_mem_wr, ex_mem_load, ex_mem_store, ex_mem_hlt;
  logic [31:0] mem_wb_alu, mem_wb_lmd;
  logic [4:0]  mem_wb_dst;
  logic        mem_wb_valid, mem_wb_wr, mem_wb_load, mem_wb_hlt;

  // Addresses wrap modulo the memory depth.
  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'(a % DEPTH_W);
  endfunction

  logic [31:0] ifetch, mem_rdata, wb_val, id_a, id_b, id_imm;
  logic        wb_fwd, wb_en, id_hlt;
  logic [4:0]  id_rs, id_rt;

  assign ifetch    = mem[widx(PC)];
  assign mem_rdata = mem[widx(ex_mem_alu)];
  assign wb_val    = mem_wb_load ? mem_wb_lmd : mem_wb_alu;
  assign wb_fwd    = mem_wb_valid && mem_wb_wr && (mem_wb_dst != 5'd0);
  assign wb_en     = wb_fwd && !HALTED;
  assign id_rs     = if_id_ir[25:21];
  assign id_rt     = if_id_ir[20:16];
  assign id_imm    = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
  assign id_hlt    = if_id_valid && (if_id_ir[31:26] == OP_HLT);
  assign halted    = HALTED;

  // ID register read; a same-cycle WB write is bypassed so write happens before read.
  always_comb begin
    id_a = 32'd0;
    id_b = 32'd0;
    if (id_rs != 5'd0) id_a = (wb_en && mem_wb_dst == id_rs) ? wb_val : reg_file[id_rs];
    if (id_rt != 5'd0) id_b = (wb_en && mem_wb_dst == id_rt) ? wb_val : reg_file[id_rt];
  end

  logic [31:0] ex_a, ex_b, alu, br_target;
  logic [4:0]  dec_dst;
  logic        dec_wr, dec_load, dec_store, br_cond, ex_taken;

  // EX operand forwarding: EX/MEM (non-load) is younger than MEM/WB, so it wins.
  always_comb begin
    ex_a = id_ex_a;
    ex_b = id_ex_b;
    if (ex_mem_valid && ex_mem_wr && !ex_mem_load && ex_mem_dst == id_ex_rs) ex_a = ex_mem_alu;
    else if (wb_fwd && mem_wb_dst == id_ex_rs) ex_a = wb_val;
    if (ex_mem_valid && ex_mem_wr && !ex_mem_load && ex_mem_dst == id_ex_rt) ex_b = ex_mem_alu;
    else if (wb_fwd && mem_wb_dst == id_ex_rt) ex_b = wb_val;
  end

  // EX decode and ALU; unknown opcodes fall through as NOPs.
  always_comb begin
    alu       = 32'd0;
    dec_dst   = id_ex_rt;
    dec_wr    = 1'b0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    br_cond   = 1'b0;
    case (id_ex_op)
      OP_ADD:  begin alu = ex_a + ex_b; dec_wr = 1'b1; dec_dst = id_ex_rd; end
      OP_SUB:  begin alu = ex_a - ex_b; dec_wr = 1'b1; dec_dst = id_ex_rd; end
      OP_AND:  begin alu = ex_a & ex_b; dec_wr = 1'b1; dec_dst = id_ex_rd; end
      OP_OR:   begin alu = ex_a | ex_b; dec_wr = 1'b1; dec_dst = id_ex_rd; end
      OP_SLT:  begin alu = {31'd0, $signed(ex_a) < $signed(ex_b)}; dec_wr = 1'b1; dec_dst = id_ex_rd; end
`ifdef MIPS32_MUL_EN
      OP_MUL:  begin alu = ex_a * ex_b; dec_wr = 1'b1; dec_dst = id_ex_rd; end
`endif
      OP_LW:   begin alu = ex_a + id_ex_imm; dec_wr = 1'b1; dec_load = 1'b1; end
      OP_SW:   begin alu = ex_a + id_ex_imm; dec_store = 1'b1; end
      OP_ADDI: begin alu = ex_a + id_ex_imm; dec_wr = 1'b1; end
      OP_SUBI: begin alu = ex_a - id_ex_imm; dec_wr = 1'b1; end
      OP_SLTI: begin alu = {31'd0, $signed(ex_a) < $signed(id_ex_imm)}; dec_wr = 1'b1; end
      OP_BNEZ: br_cond = (ex_a != 32'd0);
      OP_BEQZ: br_cond = (ex_a == 32'd0);
      default: ;
    endcase
  end

  assign ex_taken  = id_ex_valid && br_cond;
  assign br_target = id_ex_npc + id_ex_imm;

  // Pipeline registers, PC and status flags; reset empties every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC <= 32'd0; HALTED <= 1'b0; TAKEN_BRANCH <= 1'b0; fetch_stop <= 1'b0;
      if_id_ir <= 32'd0; if_id_npc <= 32'd0; if_id_valid <= 1'b0;
      id_ex_npc <= 32'd0; id_ex_a <= 32'd0; id_ex_b <= 32'd0; id_ex_imm <= 32'd0;
      id_ex_op <= 6'd0; id_ex_rs <= 5'd0; id_ex_rt <= 5'd0; id_ex_rd <= 5'd0; id_ex_valid <= 1'b0;
      ex_mem_alu <= 32'd0; ex_mem_b <= 32'd0; ex_mem_dst <= 5'd0; ex_mem_valid <= 1'b0;
      ex_mem_wr <= 1'b0; ex_mem_load <= 1'b0; ex_mem_store <= 1'b0; ex_mem_hlt <= 1'b0;
      mem_wb_alu <= 32'd0; mem_wb_lmd <= 32'd0; mem_wb_dst <= 5'd0; mem_wb_valid <= 1'b0;
      mem_wb_wr <= 1'b0; mem_wb_load <= 1'b0; mem_wb_hlt <= 1'b0;
    end else begin
      TAKEN_BRANCH <= ex_taken;
      // IF: a taken branch beats a halting fetch stop.
      if (ex_taken) begin
        PC          <= br_target;
        if_id_valid <= 1'b0;
      end else if (fetch_stop || id_hlt) begin
        if_id_valid <= 1'b0;
      end else begin
        PC          <= PC + 32'd1;
        if_id_ir    <= ifetch;
        if_id_npc   <= PC + 32'd1;
        if_id_valid <= 1'b1;
      end
      if (id_hlt && !ex_taken) fetch_stop <= 1'b1;
      // ID
      id_ex_valid <= if_id_valid && !ex_taken;
      id_ex_npc   <= if_id_npc;
      id_ex_a     <= id_a;
      id_ex_b     <= id_b;
      id_ex_imm   <= id_imm;
      id_ex_op    <= if_id_ir[31:26];
      id_ex_rs    <= id_rs;
      id_ex_rt    <= id_rt;
      id_ex_rd    <= if_id_ir[15:11];
      // EX
      ex_mem_valid <= id_ex_valid;
      ex_mem_alu   <= alu;
      ex_mem_b     <= ex_b;
      ex_mem_dst   <= dec_dst;
      ex_mem_wr    <= id_ex_valid && dec_wr && (dec_dst != 5'd0);
      ex_mem_load  <= id_ex_valid && dec_load;
      ex_mem_store <= id_ex_valid && dec_store;
      ex_mem_hlt   <= id_ex_valid && (id_ex_op == OP_HLT);
      // MEM
      mem_wb_valid <= ex_mem_valid;
      mem_wb_alu   <= ex_mem_alu;
      mem_wb_lmd   <= mem_rdata;
      mem_wb_dst   <= ex_mem_dst;
      mem_wb_wr    <= ex_mem_wr;
      mem_wb_load  <= ex_mem_load;
      mem_wb_hlt   <= ex_mem_hlt;
      // WB
      if (mem_wb_valid && mem_wb_hlt) HALTED <= 1'b1;
    end
  end

  // Register file write port; not reset so preloads survive.
  always_ff @(posedge clk) begin
    if (wb_en) reg_file[mem_wb_dst] <= wb_val;
  end

  // Memory store port in MEM; not reset so preloads survive.
  always_ff @(posedge clk) begin
    if (ex_mem_valid && ex_mem_store && !HALTED) mem[widx(ex_mem_alu)] <= ex_mem_b;
  end
endmodule

// File: tb/tb_mips32.sv
// tb/tb_mips32.sv - scoreboard bench for mips32: directed programs checked at halt and at reset
module tb_mips32;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  mips32 #(.MEM_DEPTH(1024)) dut (.clk(clk), .rst_n(rst_n), .halted(halted));

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_TAKEN = 3, K_HALT = 4, K_TB = 5, K_OUT = 6;
  localparam logic [31:0] HLT = 32'hfc000000;
  localparam logic [31:0] NOP = 32'hf8000000;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   taken_cnt = 0;
  logic snap = 1'b0;
  logic drained = 1'b0;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Counts TAKEN_BRANCH pulses since the last reset.
  always @(negedge clk) begin
    if (!rst_n) taken_cnt = 0;
    else if (dut.TAKEN_BRANCH) taken_cnt = taken_cnt + 1;
  end

  // Monitor: when the core halts (or a snapshot is requested) drain and compare all pending expectations.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge halted or posedge snap);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_REG:   act = dut.reg_file[e.idx];
          K_MEM:   act = dut.mem[e.idx];
          K_PC:    act = dut.PC;
          K_TAKEN: act = 32'(taken_cnt);
          K_HALT:  act = {31'd0, dut.HALTED};
          K_TB:    act = {31'd0, dut.TAKEN_BRANCH};
          default: act = {31'd0, halted};
        endcase
        n_checks = n_checks + 1;
        if (act !== e.val) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
      end
      drained = 1'b1;
    end
  end

  task automatic push(input int kind, input int idx, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) dut.mem[i] = 32'd0;
  endtask

  task automatic run_until_halt(input int budget, input string tname);
    drained = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < budget && !drained; i++) @(negedge clk);
    if (!drained) begin
      n_checks = n_checks + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s_timeout: halted still 0 after %0d cycles, expected 1", tname, budget);
      sb.delete();
    end
  endtask

  task automatic snap_check(input string tname);
    drained = 1'b0;
    snap = 1'b1;
    #2;
    if (!drained) begin
      n_checks = n_checks + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s_snapshot: monitor idle, expected drain", tname);
      sb.delete();
    end
    snap = 1'b0;
    #1;
  endtask

  task automatic load_add();
    for (int k = 0; k < 32; k++) dut.reg_file[k] = 32'(k);
    dut.mem[0] = 32'h2801000a; dut.mem[1] = 32'h28020014; dut.mem[2] = 32'h28030019;
    dut.mem[3] = 32'h0ce77800; dut.mem[4] = 32'h0ce77800; dut.mem[5] = 32'h00222000;
    dut.mem[6] = 32'h0ce77800; dut.mem[7] = 32'h00832800; dut.mem[8] = 32'hfc000000;
  endtask

  task automatic push_add(input string t);
    push(K_REG, 0, 32'd0, {t, "_r0"});  push(K_REG, 1, 32'd10, {t, "_r1"});
    push(K_REG, 2, 32'd20, {t, "_r2"}); push(K_REG, 3, 32'd25, {t, "_r3"});
    push(K_REG, 4, 32'd30, {t, "_r4"}); push(K_REG, 5, 32'd55, {t, "_r5"});
    push(K_REG, 7, 32'd7, {t, "_r7"});  push(K_REG, 15, 32'd7, {t, "_r15"});
    push(K_PC, 0, 32'd9, {t, "_pc"});   push(K_OUT, 0, 32'd1, {t, "_halted"});
  endtask

  task automatic push_reset(input string t);
    push(K_PC, 0, 32'd0, {t, "_pc"});
    push(K_HALT, 0, 32'd0, {t, "_HALTED"});
    push(K_TB, 0, 32'd0, {t, "_TAKEN_BRANCH"});
    push(K_OUT, 0, 32'd0, {t, "_halted"});
  endtask

  initial begin
    // Reset state, asserted asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    push_reset("reset");
    snap_check("reset");

    // Add program.
    do_reset();
    load_add();
    push_add("add");
    run_until_halt(40, "add");
    repeat (5) @(negedge clk);
    push(K_PC, 0, 32'd9, "add_pc_frozen");
    push(K_OUT, 0, 32'd1, "add_halted_held");
    snap_check("add_late");

    // Back-to-back forwarding.
    do_reset();
    for (int k = 1; k < 4; k++) dut.reg_file[k] = 32'h11111111;
    dut.mem[0] = enc_i(6'b001010, 5'd0, 5'd1, 16'd5);
    dut.mem[1] = enc_r(6'b000000, 5'd1, 5'd1, 5'd2);
    dut.mem[2] = enc_r(6'b000000, 5'd2, 5'd1, 5'd3);
    dut.mem[3] = HLT;
    push(K_REG, 1, 32'd5, "fwd_r1"); push(K_REG, 2, 32'd10, "fwd_r2");
    push(K_REG, 3, 32'd15, "fwd_r3"); push(K_PC, 0, 32'd4, "fwd_pc");
    run_until_halt(30, "fwd");

    // Load / store with load-use through one NOP.
    do_reset();
    dut.mem[100] = 32'd85;
    dut.reg_file[31] = 32'd100;
    dut.reg_file[2] = 32'd0;
    dut.mem[0] = enc_i(6'b001000, 5'd31, 5'd2, 16'd0);
    dut.mem[1] = NOP;
    dut.mem[2] = enc_i(6'b001010, 5'd2, 5'd2, 16'd45);
    dut.mem[3] = enc_i(6'b001001, 5'd31, 5'd2, 16'd1);
    dut.mem[4] = HLT;
    push(K_MEM, 101, 32'd130, "ls_mem101"); push(K_MEM, 100, 32'd85, "ls_mem100");
    push(K_REG, 2, 32'd130, "ls_r2");       push(K_PC, 0, 32'd5, "ls_pc");
    run_until_halt(30, "ls");

    // Factorial loop.
    do_reset();
    dut.reg_file[10] = 32'd1;
    dut.reg_file[3] = 32'd5;
    dut.mem[0] = enc_r(6'b000101, 5'd10, 5'd3, 5'd10);
    dut.mem[1] = enc_i(6'b001011, 5'd3, 5'd3, 16'd1);
    dut.mem[2] = enc_i(6'b001101, 5'd3, 5'd0, 16'hfffd);
    dut.mem[3] = HLT;
`ifdef MIPS32_MUL_EN
    push(K_REG, 10, 32'd120, "fact_r10");
`else
    push(K_REG, 10, 32'd1, "fact_r10");
`endif
    push(K_REG, 3, 32'd0, "fact_r3"); push(K_TAKEN, 0, 32'd4, "fact_taken");
    push(K_PC, 0, 32'd4, "fact_pc");
    run_until_halt(60, "fact");

    // BEQZ squashing an HLT in ID, plus SLT/SLTI/SUB/AND with signed operands.
    do_reset();
    for (int k = 1; k < 8; k++) dut.reg_file[k] = 32'h55;
    dut.mem[0] = enc_i(6'b001010, 5'd0, 5'd1, 16'd1);
    dut.mem[1] = enc_i(6'b001110, 5'd0, 5'd0, 16'd1);
    dut.mem[2] = HLT;
    dut.mem[3] = enc_i(6'b001010, 5'd1, 5'd2, 16'd4);
    dut.mem[4] = enc_r(6'b000100, 5'd1, 5'd2, 5'd3);
    dut.mem[5] = enc_i(6'b001100, 5'd2, 5'd4, 16'hffff);
    dut.mem[6] = enc_r(6'b000001, 5'd1, 5'd2, 5'd5);
    dut.mem[7] = enc_r(6'b000010, 5'd2, 5'd5, 5'd6);
    dut.mem[8] = enc_r(6'b000100, 5'd5, 5'd1, 5'd7);
    dut.mem[9] = HLT;
    push(K_REG, 1, 32'd1, "br_r1"); push(K_REG, 2, 32'd5, "br_r2");
    push(K_REG, 3, 32'd1, "br_slt"); push(K_REG, 4, 32'd0, "br_slti_neg");
    push(K_REG, 5, 32'hfffffffc, "br_sub"); push(K_REG, 6, 32'd4, "br_and");
    push(K_REG, 7, 32'd1, "br_slt_signed"); push(K_TAKEN, 0, 32'd1, "br_taken");
    push(K_PC, 0, 32'd10, "br_pc");
    run_until_halt(40, "br");

    // Halt containment.
    do_reset();
    dut.reg_file[1] = 32'd7;
    dut.mem[0] = HLT;
    dut.mem[1] = enc_i(6'b001010, 5'd0, 5'd1, 16'd99);
    push(K_REG, 1, 32'd7, "hlt_r1"); push(K_PC, 0, 32'd1, "hlt_pc");
    run_until_halt(20, "hlt");
    repeat (5) @(negedge clk);
    push(K_REG, 1, 32'd7, "hlt_r1_late"); push(K_PC, 0, 32'd1, "hlt_pc_frozen");
    snap_check("hlt_late");

    // Asynchronous reset in cycle 4 of the add program, then rerun.
    do_reset();
    load_add();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push_reset("arst");
    push(K_REG, 1, 32'd1, "arst_r1_no_partial");
    snap_check("arst");
    push_add("arst_rerun");
    run_until_halt(40, "arst_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips32.md
# mips32

Five-stage (IF, ID, EX, MEM, WB) in-order pipelined MIPS32-subset core with a unified word-addressed instruction/data memory and a 32×32 register file. It runs programs preloaded into `mem` and stops on HLT. It is the top-level compute block of the design; benches load `mem` and `reg_file` hierarchically and inspect `reg_file`, `PC`, `HALTED` and `TAKEN_BRANCH`.

## Interface
- `MEM_DEPTH`, 1024: words in unified memory; addresses are taken modulo `MEM_DEPTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `halted` output 1: mirrors internal `HALTED`; 0 in reset.
- Hierarchically visible internals with exact names:
  - `mem[0:MEM_DEPTH-1]` (32b)
  - `reg_file[0:31]` (32b)
  - `PC` (32b)
  - `HALTED`
  - `TAKEN_BRANCH`

## Operation
- Encoding: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to 32b.
- R-type opcodes, `rd = rs op rt`:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare, result 1 or 0.
  - MUL 000101: low 32 bits of the product.
- I-type opcodes, `rt` is the destination:
  - LW 001000: `rt = mem[rs+imm]`.
  - SW 001001: `mem[rs+imm] = rt`.
  - ADDI 001010, SUBI 001011, SLTI 001100.
- Branches: BNEZ 001101 and BEQZ 001110 test `rs`; target = branch PC + 1 + imm.
- HLT 111111. Any other opcode executes as a NOP.
- Arithmetic is 32-bit wrap-around with no exceptions. `PC` is a word address and increments by 1.
- R0 always reads 0; writes to R0 are discarded.
- The register file writes before it reads: a WB write is visible to ID in the same cycle.
- Forwarding:
  - ALU results forward to EX operands from EX/MEM and from MEM/WB; the youngest producer wins.
  - LW data forwards from MEM/WB only. A use immediately after LW needs one intervening instruction, supplied by software; there is no interlock.
- Branches resolve in EX.
  - Taken: `TAKEN_BRANCH`=1 for that cycle, `PC` loads the target, and the two younger instructions in IF/ID and ID/EX are squashed to NOPs.
  - Not taken: no penalty.
- HLT:
  - When HLT is in ID, fetch stops: `PC` freezes and IF inserts NOPs.
  - When HLT reaches WB, `HALTED`=1 and stays set until reset. With `HALTED`=1, no register or memory writes occur.
  - A taken branch in EX in the same cycle that HLT is in ID wins: HLT is squashed and fetch continues at the target.
- Reset (asynchronous assert, synchronous release):
  - Cleared: `PC`=0, all pipeline valid bits (every stage a NOP), `HALTED`=0, `TAKEN_BRANCH`=0.
  - Retained: `reg_file` and `mem`, so that preloads survive reset.
  - Reset mid-program aborts all in-flight instructions with no partial writes; fetch restarts at 0.

## Timing
- One instruction issued per cycle; write-back latency is 4 cycles after fetch.
- Instruction i is fetched in cycle i when no branches occur.
- A taken branch costs 2 cycles.
- For an n-instruction straight-line program ending in HLT, `HALTED` rises at the edge ending cycle n+3.
- A dependent instruction at any distance receives correct operands, except the LW→next-instruction case.
- `TAKEN_BRANCH` is a one-cycle pulse.

## Configuration
- `MIPS32_MUL_EN` defined: opcode 000101 executes MUL, using a single-cycle combinational multiply in EX.
- `MIPS32_MUL_EN` undefined: opcode 000101 is a NOP and no multiplier is synthesized.

## Test plan
- Add test:
  - Preload `reg_file[k]=k`, then `mem[0..8]` = 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000.
  - Release reset and run 30 cycles.
  - Expect R0..R5 = 0, 10, 20, 25, 30, 55; `halted`=1; `PC` frozen; R7 = 7.
- Back-to-back forwarding:
  - ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT.
  - Expect R2=10, R3=15.
- Load/store:
  - `mem[100]`=85, R31=100 preset.
  - LW R2,0(R31); NOP; ADDI R2,R2,45; SW R2,1(R31); HLT.
  - Expect `mem[101]`=130.
- Branch loop (factorial):
  - R10=1, R3=5.
  - Loop body MUL R10,R10,R3; SUBI R3,R3,1; BNEZ R3,-3 (branch back to MUL); HLT.
  - Expect R10=120, `TAKEN_BRANCH` pulsing 4 times.
  - Without `MIPS32_MUL_EN`: R10 stays 1.
- Halt containment:
  - HLT followed by ADDI R1,R0,99.
  - Expect R1 unchanged and `PC` frozen.
- Async reset mid-run:
  - Assert `rst_n` low during the add test at cycle 4.
  - Expect `PC`=0, `HALTED`=0, `TAKEN_BRANCH`=0 immediately with no clock edge.
  - After release, the program reruns to the same final values.
